// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types, opcode constants and helpers for the core sequencer
//
// Purpose : FSM state encoding, RV32 major-opcode constants, next-PC and
//           write-back source encodings, and the opcode classification
//           functions used by the sequencer.
// Ports   : none (package).

package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,  // PC + 4
    PC_REL = 2'd1,  // PC + imm (taken branch, JAL)
    PC_REG = 2'd2   // rs1 + imm (JALR)
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_LOAD,
    CLS_STORE,
    CLS_ALU,
    CLS_ALU_IMM,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_FENCE,
    CLS_SYSTEM
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP:     return CLS_ALU;
      OPC_OP_IMM: return CLS_ALU_IMM;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_FENCE:  return CLS_FENCE;
      OPC_SYSTEM: return CLS_SYSTEM;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

  // Instructions whose ALU operand B is the immediate.
  function automatic logic uses_imm(input op_class_t c);
    return (c == CLS_ALU_IMM) || (c == CLS_LOAD) || (c == CLS_STORE) ||
           (c == CLS_JALR) || (c == CLS_AUIPC);
  endfunction

  function automatic wb_sel_t wb_sel_of(input op_class_t c);
    case (c)
      CLS_LOAD:          return WB_MEM;
      CLS_JAL, CLS_JALR: return WB_PC4;
      CLS_LUI:           return WB_IMM;
      default:           return WB_ALU;
    endcase
  endfunction

  function automatic pc_sel_t wb_pc_sel_of(input op_class_t c);
    case (c)
      CLS_JAL:  return PC_REL;
      CLS_JALR: return PC_REG;
      default:  return PC_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - decoder/memory/datapath control bundle of the core sequencer
//
// Purpose : groups every non-clock, non-reset signal of the sequencer.
// Ports   : i_dec_op/i_dec_valid     decoder opcode and recognised flag
//           i_branch_taken           branch comparison result
//           i_mem_ack                memory completion
//           o_mem_req/we/sel_data    memory request, store, address source
//           o_ir_we, o_pc_we/o_pc_sel, o_rf_we/o_wb_sel, o_alu_src_imm
//           o_state, o_trap, o_retire, o_retire_cnt
// Modports: master = sequencer side, slave = environment side.

interface core_sequencer_if;
  logic [6:0]  i_dec_op;
  logic        i_dec_valid;
  logic        i_branch_taken;
  logic        i_mem_ack;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_mem_sel_data;
  logic        o_ir_we;
  logic        o_pc_we;
  logic [1:0]  o_pc_sel;
  logic        o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_alu_src_imm;
  logic [2:0]  o_state;
  logic        o_trap;
  logic        o_retire;
  logic [31:0] o_retire_cnt;

  modport master (
    input  i_dec_op, i_dec_valid, i_branch_taken, i_mem_ack,
    output o_mem_req, o_mem_we, o_mem_sel_data, o_ir_we, o_pc_we, o_pc_sel,
           o_rf_we, o_wb_sel, o_alu_src_imm, o_state, o_trap, o_retire,
           o_retire_cnt
  );

  modport slave (
    output i_dec_op, i_dec_valid, i_branch_taken, i_mem_ack,
    input  o_mem_req, o_mem_we, o_mem_sel_data, o_ir_we, o_pc_we, o_pc_sel,
           o_rf_we, o_wb_sel, o_alu_src_imm, o_state, o_trap, o_retire,
           o_retire_cnt
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle instruction sequencer FSM
//
// Purpose : steps each instruction through FETCH, DECODE, EXEC, MEM and WB,
//           driving memory, PC, register-file and ALU-operand controls, with
//           a sticky TRAP state and a retired-instruction counter.
// Ports   : i_clk    sole clock, rising edge
//           i_rst_n  synchronous active-low reset
//           bus      core_sequencer_if.master (decoder, memory and datapath)

module core_sequencer
  import core_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  core_sequencer_if.master bus
);

  state_t      state_q, state_d;
  logic [6:0]  op_q;
  logic [6:0]  op_d;
  op_class_t   cls_q, cls_d;
  logic [31:0] retire_cnt_q;

  // Registered controls that are a function of the state being entered.
  logic        mem_req_q, mem_we_q, mem_sel_q, rf_we_q, alu_imm_q, trap_q;
  wb_sel_t     wb_sel_q;

  // Strobes that react to same-cycle inputs (ack, branch result).
  logic        ir_we, pc_we, retire;
  pc_sel_t     pc_sel;

  // The opcode that will be in op_q once the current edge has been taken, so
  // controls registered on entry to EXEC already see the new instruction.
  assign op_d  = (state_q == ST_DECODE) ? bus.i_dec_op : op_q;
  assign cls_q = classify(op_q);
  assign cls_d = classify(op_d);

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_SEQ;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.i_mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = bus.i_dec_valid ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_ALU, CLS_ALU_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR:
            state_d = ST_WB;
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = bus.i_branch_taken ? PC_REL : PC_SEQ;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_FENCE: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          // SYSTEM is unsupported; unknown opcodes that slipped past the
          // decoder trap as well rather than retiring silently.
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (bus.i_mem_ack) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        pc_we   = 1'b1;
        pc_sel  = wb_pc_sel_of(cls_q);
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 7'd0;
      retire_cnt_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      wb_sel_q     <= WB_ALU;
      alu_imm_q    <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= bus.i_dec_op;
      end
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
      mem_req_q <= (state_d == ST_FETCH) || (state_d == ST_MEM);
      mem_sel_q <= (state_d == ST_MEM);
      mem_we_q  <= (state_d == ST_MEM) && (cls_d == CLS_STORE);
      rf_we_q   <= (state_d == ST_WB);
      wb_sel_q  <= (state_d == ST_WB) ? wb_sel_of(cls_d) : WB_ALU;
      alu_imm_q <= (state_d inside {ST_EXEC, ST_MEM, ST_WB}) && uses_imm(cls_d);
      trap_q    <= trap_q || (state_d == ST_TRAP);
    end
  end

  // Input-driven strobes are masked while reset is asserted so an abandoned
  // transaction cannot retire or write anything on its way out.
  assign bus.o_ir_we        = ir_we & i_rst_n;
  assign bus.o_pc_we        = pc_we & i_rst_n;
  assign bus.o_pc_sel       = i_rst_n ? pc_sel : PC_SEQ;
  assign bus.o_retire       = retire & i_rst_n;
  assign bus.o_mem_req      = mem_req_q;
  assign bus.o_mem_we       = mem_we_q;
  assign bus.o_mem_sel_data = mem_sel_q;
  assign bus.o_rf_we        = rf_we_q;
  assign bus.o_wb_sel       = wb_sel_q;
  assign bus.o_alu_src_imm  = alu_imm_q;
  assign bus.o_state        = state_q;
  assign bus.o_trap         = trap_q;
  assign bus.o_retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard testbench for core_sequencer

module tb_core_sequencer;

  typedef struct {
    logic [6:0] op;
    bit         valid;
    bit         taken;
    int         fd;     // fetch ack after this many wait cycles
    int         dd;     // data ack after this many wait cycles
  } stim_t;

  typedef struct {
    int         lat;
    logic [1:0] pc_sel;
    bit         rf_we;
    logic [1:0] wb_sel;
    bit         alu_imm;
    bit         is_store;
    logic [2:0] state;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_cnt = 32'd0;
  stim_t stim_q[$];
  exp_t  exp_q[$];
  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b1100011, 7'b0001111};

  core_sequencer_if bus();

  core_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'd0, bus.o_mem_req, bus.o_mem_we, bus.o_mem_sel_data, bus.o_ir_we,
            bus.o_pc_we, bus.o_pc_sel, bus.o_rf_we, bus.o_wb_sel, bus.o_alu_src_imm,
            bus.o_state, bus.o_trap, bus.o_retire, bus.o_retire_cnt};
  endfunction

  // Expected retire-time behaviour taken from the instruction-class rules.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    e.lat = 4 + s.fd; e.pc_sel = 2'd0; e.rf_we = 1'b1; e.wb_sel = 2'd0;
    e.alu_imm = 1'b0; e.is_store = 1'b0; e.state = 3'd5;
    case (s.op)
      7'b0000011: begin e.lat = 5 + s.fd + s.dd; e.wb_sel = 2'd1; e.alu_imm = 1'b1; end
      7'b0100011: begin e.lat = 4 + s.fd + s.dd; e.rf_we = 1'b0; e.alu_imm = 1'b1;
                        e.is_store = 1'b1; e.state = 3'd4; end
      7'b1100011: begin e.lat = 3 + s.fd; e.rf_we = 1'b0; e.state = 3'd3;
                        e.pc_sel = s.taken ? 2'd1 : 2'd0; end
      7'b0001111: begin e.lat = 3 + s.fd; e.rf_we = 1'b0; e.state = 3'd3; end
      7'b1101111: begin e.pc_sel = 2'd1; e.wb_sel = 2'd2; end
      7'b1100111: begin e.pc_sel = 2'd2; e.wb_sel = 2'd2; e.alu_imm = 1'b1; end
      7'b0110111: e.wb_sel = 2'd3;
      7'b0010111: e.alu_imm = 1'b1;
      7'b0010011: e.alu_imm = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Driver: issues one instruction at a time and plays the memory.
  initial begin : driver
    stim_t cur;
    int wait_cnt, dly;
    bit need_issue, active, saw_retire;
    wait_cnt = 0; need_issue = 1; active = 0; saw_retire = 0;
    cur = '{7'd0, 1'b0, 1'b0, 0, 0};
    bus.i_mem_ack = 1'b0; bus.i_dec_op = 7'd0;
    bus.i_dec_valid = 1'b0; bus.i_branch_taken = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.i_mem_ack = 1'b0; wait_cnt = 0; need_issue = 1; active = 0; saw_retire = 0;
      end else begin
        if (bus.i_mem_ack) begin
          bus.i_mem_ack = 1'b0;
          wait_cnt = 0;
        end
        if (saw_retire) begin
          need_issue = 1;
          active = 0;
        end
        if (need_issue && stim_q.size() > 0) begin
          cur = stim_q.pop_front();
          need_issue = 0; active = 1; wait_cnt = 0;
          bus.i_dec_op = cur.op;
          bus.i_dec_valid = cur.valid;
          bus.i_branch_taken = cur.taken;
          if (cur.valid) exp_q.push_back(model(cur));
        end
        if (active && bus.o_mem_req) begin
          dly = bus.o_mem_sel_data ? cur.dd : cur.fd;
          if (wait_cnt == dly) bus.i_mem_ack = 1'b1;
          else wait_cnt++;
        end
      end
      @(negedge clk);
      saw_retire = bus.o_retire;
    end
  end

  // Monitor: compares every retirement against the scoreboard.
  initial begin : monitor
    exp_t e;
    int lat, ir_cnt;
    bit prev_wait;
    logic [2:0] prev_mem;
    lat = 0; ir_cnt = 0; prev_wait = 0; prev_mem = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat = 0; ir_cnt = 0; prev_wait = 0;
        exp_q.delete();
        model_cnt = 32'd0;
      end else begin
        if (prev_wait)
          check("mem_stable", 64'({bus.o_mem_req, bus.o_mem_we, bus.o_mem_sel_data}), 64'(prev_mem));
        prev_wait = bus.o_mem_req && !bus.i_mem_ack;
        prev_mem = {bus.o_mem_req, bus.o_mem_we, bus.o_mem_sel_data};
        if (bus.o_ir_we) ir_cnt++;
        if (exp_q.size() > 0 && bus.o_state != 3'd0) lat++;
        if (bus.o_mem_req && bus.o_mem_sel_data && exp_q.size() > 0)
          check("mem_we", 64'(bus.o_mem_we), 64'(exp_q[0].is_store));
        if (bus.o_rf_we && !bus.o_retire)
          check("rf_we_without_retire", 64'(bus.o_rf_we), 64'd0);
        if (bus.o_retire) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 64'(bus.o_retire), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 64'(lat), 64'(e.lat));
            check("retire_state", 64'(bus.o_state), 64'(e.state));
            check("pc_we", 64'(bus.o_pc_we), 64'd1);
            check("pc_sel", 64'(bus.o_pc_sel), 64'(e.pc_sel));
            check("rf_we", 64'(bus.o_rf_we), 64'(e.rf_we));
            if (e.rf_we) check("wb_sel", 64'(bus.o_wb_sel), 64'(e.wb_sel));
            check("alu_src_imm", 64'(bus.o_alu_src_imm), 64'(e.alu_imm));
            check("ir_we_count", 64'(ir_cnt), 64'd1);
            check("retire_cnt", 64'(bus.o_retire_cnt), 64'(model_cnt));
            model_cnt = model_cnt + 32'd1;
            lat = 0;
            ir_cnt = 0;
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int to;
    to = 0;
    while (to < 20000 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
      @(negedge clk);
      to++;
    end
    check(name, 64'(stim_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin : main
    stim_t s;
    int to, bad;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed: ADDI, LW with 3-cycle data ack, BEQ taken then not taken.
    stim_q.push_back('{7'b0010011, 1'b1, 1'b0, 0, 0});
    stim_q.push_back('{7'b0000011, 1'b1, 1'b0, 0, 3});
    stim_q.push_back('{7'b1100011, 1'b1, 1'b1, 0, 0});
    stim_q.push_back('{7'b1100011, 1'b1, 1'b0, 0, 0});
    for (int i = 0; i < 200; i++) begin
      s.op = ops[$urandom_range(0, 9)];
      s.valid = 1'b1;
      s.taken = 1'($urandom_range(0, 1));
      s.fd = int'($urandom_range(0, 3));
      s.dd = int'($urandom_range(0, 3));
      stim_q.push_back(s);
    end
    drain("drain_random");

    // Unrecognised opcode: sticky trap, no memory traffic.
    stim_q.push_back('{7'b0000000, 1'b0, 1'b0, 0, 0});
    to = 0;
    while (to < 50 && bus.o_trap !== 1'b1) begin
      @(negedge clk);
      to++;
    end
    check("trap_entered", 64'(bus.o_trap), 64'd1);
    check("trap_state", 64'(bus.o_state), 64'd6);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_trap !== 1'b1 || bus.o_mem_req || bus.o_retire || bus.o_ir_we ||
          bus.o_pc_we || bus.o_rf_we)
        bad++;
    end
    check("trap_hold", 64'(bad), 64'd0);

    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_from_trap", all_outs(), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset during a stalled data phase abandons the load.
    stim_q.push_back('{7'b0000011, 1'b1, 1'b0, 0, 40});
    to = 0;
    while (to < 50 && bus.o_mem_sel_data !== 1'b1) begin
      @(negedge clk);
      to++;
    end
    check("reached_mem", 64'(bus.o_mem_sel_data), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_mid_mem", all_outs(), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Counter wrap from a forced all-ones value.
    repeat (3) @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_cnt_q;
    @(negedge clk);
    check("cnt_preload", 64'(bus.o_retire_cnt), 64'hFFFF_FFFF);
    stim_q.push_back('{7'b0001111, 1'b1, 1'b0, 0, 0});
    drain("drain_wrap");
    @(negedge clk);
    check("cnt_wrap", 64'(bus.o_retire_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
